// File: rtl/envelope_follower_if.sv
// Envelope follower port bundle: per-sample audio in, rate/level controls, envelope and gate out.
// master: drives low_strobe, sample_in, a, r, threshold, hold; observes envelope_out, gate_out, gate_rise.
// slave:  the follower itself; samples the strobe, sample and controls, drives the three outputs.
interface envelope_follower_if #(
   parameter int SAMPLE_WIDTH     = 16,
   parameter int ACCUMULATOR_BITS = 24,
   parameter int CTRL_WIDTH       = 4
);
   logic                           low_strobe;
   logic signed [SAMPLE_WIDTH-1:0] sample_in;
   logic [CTRL_WIDTH-1:0]          a;
   logic [CTRL_WIDTH-1:0]          r;
   logic [CTRL_WIDTH-1:0]          threshold;
   logic [CTRL_WIDTH-1:0]          hold;
   logic [ACCUMULATOR_BITS-1:0]    envelope_out;
   logic                           gate_out;
   logic                           gate_rise;

   modport master (
      output low_strobe, sample_in, a, r, threshold, hold,
      input  envelope_out, gate_out, gate_rise
   );

   modport slave (
      input  low_strobe, sample_in, a, r, threshold, hold,
      output envelope_out, gate_out, gate_rise
   );
endinterface

// File: rtl/envelope_follower.sv
// Envelope follower + gate: rectified sample drives an attack/release envelope; a 3-state FSM derives a gate.
// Latency: envelope_out is updated one clk after each low_strobe edge; the gate lags the envelope by one strobe.
// Backpressure: none; one update per strobe cycle, all state holds between strobes.
// Ports: clk, rst (async active-low), bus (slave modport: low_strobe, sample_in, a, r, threshold, hold,
//        envelope_out, gate_out, gate_rise).
// Option: define ENVELOPE_FOLLOWER_HYSTERESIS_EN to close the gate at half the open level.
module envelope_follower #(
   parameter int SAMPLE_WIDTH     = 16,
   parameter int ACCUMULATOR_BITS = 24,
   parameter int CTRL_WIDTH       = 4,
   parameter int HOLD_BITS        = 12
) (
   input logic                clk,
   input logic                rst,
   envelope_follower_if.slave bus
);

   localparam int SCALE_SHIFT = ACCUMULATOR_BITS - SAMPLE_WIDTH + 1;
   localparam int LEVEL_SHIFT = ACCUMULATOR_BITS - CTRL_WIDTH;

   localparam logic [ACCUMULATOR_BITS-1:0] FULL_SCALE = {ACCUMULATOR_BITS{1'b1}};
   localparam logic [SAMPLE_WIDTH-1:0]     MOST_NEG   = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};
   localparam logic [SAMPLE_WIDTH-1:0]     MOST_POS   = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
   localparam logic [CTRL_WIDTH:0]         REL_BIAS   = 4;
   localparam logic [HOLD_BITS-1:0]        HOLD_LAST  = 1;

   typedef enum logic [1:0] {
      ST_OFF  = 2'd0,
      ST_OPEN = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   state_t                      state, state_nxt;
   logic [ACCUMULATOR_BITS-1:0] env, env_nxt;
   logic [HOLD_BITS-1:0]        hold_cnt, hold_cnt_nxt;
   logic                        gate_rise_q, gate_rise_nxt;

   logic [SAMPLE_WIDTH-1:0]     mag;
   logic [ACCUMULATOR_BITS-1:0] target;
   logic [ACCUMULATOR_BITS-1:0] attack_step, release_step;
   logic [ACCUMULATOR_BITS-1:0] up_diff, dn_diff;
   logic [CTRL_WIDTH:0]         rel_shift;
   logic [ACCUMULATOR_BITS-1:0] open_lvl, close_lvl;
   logic [HOLD_BITS-1:0]        hold_load;

   // Rectify; the most-negative code has no positive twin, so it saturates.
   always_comb begin
      mag = bus.sample_in;
      if (bus.sample_in[SAMPLE_WIDTH-1]) begin
         if (bus.sample_in == MOST_NEG) mag = MOST_POS;
         else                           mag = -bus.sample_in;
      end
   end

   // mag's top bit is always 0, so the shift only drops a zero.
   assign target       = ACCUMULATOR_BITS'(mag) << SCALE_SHIFT;
   assign attack_step  = FULL_SCALE >> bus.a;
   assign rel_shift    = {1'b0, bus.r} + REL_BIAS;
   assign release_step = FULL_SCALE >> rel_shift;
   assign up_diff      = target - env;
   assign dn_diff      = env - target;

   // Step is clamped to the remaining distance, so env lands exactly on target and never wraps.
   always_comb begin
      env_nxt = env;
      if (target > env) env_nxt = env + ((attack_step < up_diff) ? attack_step : up_diff);
      else              env_nxt = env - ((release_step < dn_diff) ? release_step : dn_diff);
   end

   assign open_lvl  = ACCUMULATOR_BITS'(bus.threshold) << LEVEL_SHIFT;
`ifdef ENVELOPE_FOLLOWER_HYSTERESIS_EN
   assign close_lvl = open_lvl >> 1;
`else
   assign close_lvl = open_lvl;
`endif
   assign hold_load = HOLD_BITS'({bus.hold, 8'h00});

   // Gate FSM looks at the registered env, i.e. the envelope before this strobe's update.
   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      gate_rise_nxt = 1'b0;
      if (bus.low_strobe) begin
         case (state)
            ST_OFF: begin
               if (env >= open_lvl) begin
                  state_nxt     = ST_OPEN;
                  gate_rise_nxt = 1'b1;
               end
            end
            ST_OPEN: begin
               if (env < close_lvl) begin
                  if (bus.hold == '0) begin
                     state_nxt = ST_OFF;
                  end else begin
                     state_nxt    = ST_HOLD;
                     hold_cnt_nxt = hold_load;
                  end
               end
            end
            ST_HOLD: begin
               // Retrigger returns to OPEN silently: the gate never dropped.
               if (env >= open_lvl)          state_nxt    = ST_OPEN;
               else if (hold_cnt == HOLD_LAST) state_nxt  = ST_OFF;
               else                          hold_cnt_nxt = hold_cnt - 1'b1;
            end
            default: state_nxt = ST_OFF;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= ST_OFF;
         env         <= '0;
         hold_cnt    <= '0;
         gate_rise_q <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_cnt_nxt;
         gate_rise_q <= gate_rise_nxt;
         if (bus.low_strobe) env <= env_nxt;
      end
   end

   assign bus.envelope_out = env;
   assign bus.gate_out     = (state != ST_OFF);
   assign bus.gate_rise    = gate_rise_q;

endmodule

// File: tb/tb_envelope_follower.sv
// Directed bench for envelope_follower: reset, attack clamp, rectification, release, gate hold and retrigger.
// Latency: outputs are sampled on the negedge following each strobe's posedge.
// Backpressure: none; the bench drives one strobe per call.
module tb_envelope_follower;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;
   int   rises;
   int   lows;

`ifdef ENVELOPE_FOLLOWER_HYSTERESIS_EN
   // First zero strobe leaving env below 0x400000: 0xFFFE00 - 12*0x0FFFFF.
   localparam int          J_CLOSE   = 12;
   localparam logic [31:0] ENV_CLOSE = 32'h003FFE0C;
`else
   // First zero strobe leaving env below 0x800000: 0xFFFE00 - 8*0x0FFFFF.
   localparam int          J_CLOSE   = 8;
   localparam logic [31:0] ENV_CLOSE = 32'h007FFE08;
`endif

   envelope_follower_if #(.SAMPLE_WIDTH(16), .ACCUMULATOR_BITS(24), .CTRL_WIDTH(4)) bus ();

   envelope_follower #(
      .SAMPLE_WIDTH(16), .ACCUMULATOR_BITS(24), .CTRL_WIDTH(4), .HOLD_BITS(12)
   ) dut (
      .clk (clk),
      .rst (rst_n),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic strobe(input logic [15:0] s);
      @(negedge clk);
      bus.sample_in  = s;
      bus.low_strobe = 1'b1;
      @(negedge clk);
      bus.low_strobe = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      bus.low_strobe = 1'b0;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0;
      bus.low_strobe = 1'b0; bus.sample_in = '0;
      bus.a = 4'd4; bus.r = 4'd0; bus.threshold = 4'd0; bus.hold = 4'd0;
      #12;
      check("reset_env",  32'(bus.envelope_out), 32'h0);
      check("reset_gate", 32'(bus.gate_out),     32'h0);
      check("reset_rise", 32'(bus.gate_rise),    32'h0);
      @(negedge clk); rst_n = 1'b1;

      // threshold 0: gate opens on the first strobe; then async reset mid-rise.
      strobe(16'h7FFF);
      check("thr0_env1",  32'(bus.envelope_out), 32'h000FFFFF);
      check("thr0_rise",  32'(bus.gate_rise),    32'h1);
      check("thr0_gate",  32'(bus.gate_out),     32'h1);
      strobe(16'h7FFF);
      strobe(16'h7FFF);
      check("thr0_env3",  32'(bus.envelope_out), 32'h002FFFFD);
      check("thr0_still", 32'(bus.gate_out),     32'h1);
      #2 rst_n = 1'b0;
      #1;
      check("arst_env",  32'(bus.envelope_out), 32'h0);
      check("arst_gate", 32'(bus.gate_out),     32'h0);
      check("arst_rise", 32'(bus.gate_rise),    32'h0);
      #3 rst_n = 1'b1;
      strobe(16'h7FFF);
      check("arst_resume_env",  32'(bus.envelope_out), 32'h000FFFFF);
      check("arst_resume_rise", 32'(bus.gate_rise),    32'h1);

      // Attack clamp: a=4, full scale.
      do_reset();
      bus.threshold = 4'd15; bus.a = 4'd4;
      for (int k = 1; k <= 20; k++) begin
         strobe(16'h7FFF);
         if (k == 1)  check("atk_s1",  32'(bus.envelope_out), 32'h000FFFFF);
         if (k == 15) check("atk_s15", 32'(bus.envelope_out), 32'h00EFFFF1);
         if (k == 16) check("atk_s16", 32'(bus.envelope_out), 32'h00FFFE00);
         if (k == 20) check("atk_s20", 32'(bus.envelope_out), 32'h00FFFE00);
      end
      repeat (5) @(negedge clk);
      check("idle_hold_env", 32'(bus.envelope_out), 32'h00FFFE00);

      // Rectification and release step.
      do_reset();
      bus.a = 4'd0;
      strobe(16'h8000);
      check("negfs_env", 32'(bus.envelope_out), 32'h00FFFE00);
      strobe(16'h8001);
      check("neg8001_env", 32'(bus.envelope_out), 32'h00FFFE00);
      bus.r = 4'd15;
      strobe(16'h0000);
      check("rel_r15", 32'(bus.envelope_out), 32'h00FFFDE1);
      bus.r = 4'd0;
      strobe(16'hC000);
      check("rel_to_half", 32'(bus.envelope_out), 32'h00EFFDE2);

      // Gate with hold.
      do_reset();
      bus.a = 4'd0; bus.r = 4'd0; bus.threshold = 4'd8; bus.hold = 4'd1;
      strobe(16'h7FFF);
      check("gate_env1",  32'(bus.envelope_out), 32'h00FFFE00);
      check("gate_lag",   32'(bus.gate_out),     32'h0);
      check("gate_nrise", 32'(bus.gate_rise),    32'h0);
      strobe(16'h7FFF);
      check("gate_rise",  32'(bus.gate_rise),    32'h1);
      check("gate_open",  32'(bus.gate_out),     32'h1);
      @(negedge clk);
      check("gate_rise_1clk", 32'(bus.gate_rise), 32'h0);
      rises = 0; lows = 0;
      for (int k = 1; k <= J_CLOSE; k++) begin
         strobe(16'h0000);
         rises += int'(bus.gate_rise);
         lows  += int'(!bus.gate_out);
      end
      check("close_env", 32'(bus.envelope_out), ENV_CLOSE);
      for (int k = 1; k <= 256; k++) begin
         strobe(16'h0000);
         rises += int'(bus.gate_rise);
         lows  += int'(!bus.gate_out);
      end
      check("hold_gate_high_cnt", 32'(lows), 32'h0);
      check("hold_last_high", 32'(bus.gate_out), 32'h1);
      strobe(16'h0000);
      check("hold_drop", 32'(bus.gate_out), 32'h0);
      check("hold_no_rise", 32'(rises), 32'h0);
      check("decay_env0", 32'(bus.envelope_out), 32'h0);

      // Retrigger during HOLD at count 100.
      do_reset();
      strobe(16'h7FFF);
      strobe(16'h7FFF);
      rises = 0; lows = 0;
      for (int k = 1; k <= J_CLOSE + 1 + 156; k++) begin
         strobe(16'h0000);
         rises += int'(bus.gate_rise);
         lows  += int'(!bus.gate_out);
      end
      strobe(16'h7FFF);
      rises += int'(bus.gate_rise);
      strobe(16'h7FFF);
      rises += int'(bus.gate_rise);
      check("retrig_gate", 32'(bus.gate_out), 32'h1);
      for (int k = 1; k <= J_CLOSE + 256; k++) begin
         strobe(16'h0000);
         rises += int'(bus.gate_rise);
         lows  += int'(!bus.gate_out);
      end
      check("retrig_stay_high", 32'(lows), 32'h0);
      strobe(16'h0000);
      check("retrig_drop", 32'(bus.gate_out), 32'h0);
      check("retrig_no_rise", 32'(rises), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/envelope_follower.md
# envelope_follower

Envelope follower and signal gate: the analysis counterpart to the ADSR generator. The ADSR block synthesizes a volume envelope from a gate. This block does the reverse: it measures the envelope of an incoming audio stream and derives a gate from it. It runs at master clock, advances once per sample-rate `low_strobe` (48 kHz), and produces a 24-bit envelope on the same scale as the ADSR output. Typical uses are level-triggered envelopes, noise gating and metering.

## Interface
- `SAMPLE_WIDTH`, 16, width of signed two's-complement input sample.
- `ACCUMULATOR_BITS`, 24, envelope width; must be ≥ 20 and > `SAMPLE_WIDTH`.
- `CTRL_WIDTH`, 4, width of rate/threshold/hold control codes.
- `HOLD_BITS`, 12, hold counter width; must be ≥ `CTRL_WIDTH` + 8.

Ports:
- `clk`  in  1  master clock.
- `rst`  in  1  asynchronous, active-low reset.
- `low_strobe`  in  1  one-`clk` pulse per audio sample.
- `sample_in`  in  `SAMPLE_WIDTH`  signed audio sample, valid when `low_strobe`=1.
- `a`  in  `CTRL_WIDTH`  attack rate code.
- `r`  in  `CTRL_WIDTH`  release rate code.
- `threshold`  in  `CTRL_WIDTH`  gate open level code.
- `hold`  in  `CTRL_WIDTH`  gate hold time code.
- `envelope_out`  out  `ACCUMULATOR_BITS`  current envelope, unsigned.
- `gate_out`  out  1  gate, high while state ≠ OFF.
- `gate_rise`  out  1  one-`clk` pulse on the OFF→OPEN transition.

## Operation
- **Rectify.** `mag = |sample_in|`. The most-negative code saturates to `2^(SAMPLE_WIDTH-1)-1`.
- **Scale.** `target = mag << (ACCUMULATOR_BITS - SAMPLE_WIDTH + 1)`.
- **Step sizes.**
  - `attack_step = (2^ACCUMULATOR_BITS - 1) >> a`.
  - `release_step = (2^ACCUMULATOR_BITS - 1) >> (r + 4)`.
- **Envelope update**, on each strobe:
  - if `target > env`: `env += min(attack_step, target - env)`;
  - else: `env -= min(release_step, env - target)`.
  - No overshoot and no wrap.
- **Levels.**
  - `open_lvl = threshold << (ACCUMULATOR_BITS - CTRL_WIDTH)`.
  - `close_lvl` per Configuration.
- **Hold load.** `hold_cnt` loads `hold << 8`, i.e. hold code × 256 samples.
- **Gate FSM.** States OFF, OPEN, HOLD. It evaluates only on strobe cycles, using the registered (pre-update) `env`.
  - OFF: if `env >= open_lvl`, go to OPEN and pulse `gate_rise`.
  - OPEN: if `env < close_lvl`:
    - if `hold` = 0, go to OFF;
    - else go to HOLD and load `hold_cnt`.
  - HOLD: if `env >= open_lvl`, go to OPEN with no `gate_rise` pulse.
  - HOLD, otherwise: if `hold_cnt` = 1, go to OFF; else decrement `hold_cnt`.
- `threshold` = 0 opens the gate on the first strobe after reset. The gate then never closes, because `env < 0` is impossible.
- Control inputs are sampled on every strobe. A change takes effect on the next strobe with no glitch.

## Timing
- Reset (async, `rst`=0) clears `env`, `hold_cnt`, state=OFF, `gate_out`=0 and `gate_rise`=0. Reset mid-operation clears immediately.
- `envelope_out`, `gate_out` and `gate_rise` are all registered.
- `envelope_out` reflects a sample one `clk` after the strobe edge.
- The gate decision uses the previous envelope, so the gate lags the envelope by one strobe.
- Non-strobe cycles: all state holds and `gate_rise`=0.
- `low_strobe` held high for multiple cycles is treated as one strobe per cycle. No protection is provided.

## Configuration
- `ENVELOPE_FOLLOWER_HYSTERESIS_EN` defined: `close_lvl = open_lvl >> 1`.
- `ENVELOPE_FOLLOWER_HYSTERESIS_EN` undefined: `close_lvl = open_lvl`, i.e. no hysteresis.

## Test plan
- **Reset mid-run.** Pulse `rst`=0 asynchronously between clock edges while the envelope is rising → `envelope_out`=0, `gate_out`=0 and `gate_rise`=0 without waiting for a clock edge; normal update resumes on the first strobe after release.
- **Attack clamp.** Defaults, `a`=4, constant `sample_in`=0x7FFF.
  - Expect `env` = 0x0FFFFF after strobe 1.
  - Expect `env` = 0xFFFE00 after strobe 16, exactly, with no overshoot.
  - Expect `env` to stay at 0xFFFE00 thereafter.
- **Negative full-scale.** `sample_in`=0x8000, `a`=0 → `env` = 0xFFFE00 after one strobe, identical to 0x7FFF.
- **Gate with hold.** Hysteresis enabled, `threshold`=8, `hold`=1, `r`=0. Stimulus: full-scale, then zeros.
  - `gate_rise` pulses once, the strobe after `env` ≥ 0x800000.
  - Once `env` < 0x400000, `gate_out` stays high for exactly 256 more strobes, then drops.
- **Retrigger in HOLD.** In the previous scenario, reapply full-scale at HOLD count 100 → state returns to OPEN, `gate_out` stays high, and `gate_rise` does not pulse.
- **Hysteresis disabled.** Macro undefined, same stimulus → HOLD entered on the first strobe with `env` < 0x800000.
